// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with a programmable modulus.
// Supports parallel load with range checking, hold, and cascading through
// registered carry/borrow pulses. Digit 0 (least significant) lives in [3:0].
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en_i,
  input  logic                up_i,
  input  logic                down_i,
  input  logic                hold_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                carry_o,
  output logic                borrow_o,
  output logic                load_err_o,
  output logic                at_zero_o,
  output logic                at_max_o
);

  localparam int W      = 4 * DIGITS;
  localparam int MAX_MOD = 10 ** DIGITS;

  // Reject illegal parameterisations at elaboration time
  generate
    if (DIGITS < 1 || DIGITS > 4) begin : gBadDigits
      $error("bcd_mod_counter: DIGITS must be in 1..4");
    end
    if (MODULUS < 2 || MODULUS > MAX_MOD) begin : gBadModulus
      $error("bcd_mod_counter: MODULUS must be in 2..10**DIGITS");
    end
  endgenerate

  // Converts a binary constant to packed BCD; used only at elaboration
  function automatic logic [W-1:0] toBcd(input int value);
    int            v;
    logic [W-1:0]  r;
    v = value;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // BCD increment by one; a digit at 9 wraps to 0 and ripples upward
  function automatic logic [W-1:0] bcdInc(input logic [W-1:0] value);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   digit;
    r = value;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (c) begin
        if (digit == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = digit + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement by one; a digit at 0 wraps to 9 and borrows upward
  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] value);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   digit;
    r = value;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (b) begin
        if (digit == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = digit - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Terminal count in BCD; valid BCD vectors order the same as unsigned binary,
  // so range checks compare the packed BCD directly
  localparam logic [W-1:0] MAX_BCD = toBcd(MODULUS - 1);

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         loadErr_q, loadErr_d;
  logic         loadDigitsOk;
  logic         loadOk;
  logic         atZero;
  logic         atMax;

  assign atZero = (count_q == '0);
  assign atMax  = (count_q == MAX_BCD);

  // Load is accepted only when every digit is decimal and the value is in range
  always_comb begin
    loadDigitsOk = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val_i[4*i +: 4] > 4'd9) begin
        loadDigitsOk = 1'b0;
      end
    end
    loadOk = loadDigitsOk && (load_val_i <= MAX_BCD);
  end

  // Next count and pulse selection, priority hold > load > up > down
  always_comb begin
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    loadErr_d = 1'b0;
    if (hold_i) begin
      count_d = count_q;
    end else if (load_i) begin
      if (loadOk) begin
        count_d = load_val_i;
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (up_i && step_en_i) begin
      if (atMax) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = bcdInc(count_q);
      end
    end else if (down_i && !up_i && step_en_i) begin
      if (atZero) begin
        count_d  = MAX_BCD;
        borrow_d = 1'b1;
      end else begin
        count_d = bcdDec(count_q);
      end
    end
  end

  // Count and pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      loadErr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign count_o    = count_q;
  assign carry_o    = carry_q;
  assign borrow_o   = borrow_q;
  assign load_err_o = loadErr_q;
  assign at_zero_o  = atZero;
  assign at_max_o   = atMax;

endmodule
